// File: rtl/axi4_lite_sram.sv
// AXI4-Lite slave in front of a word-organised SRAM. Read and write channels
// run independent FSMs with a programmable number of wait cycles each.
module axi4_lite_sram #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned WR_LAT      = 1
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        pAXI4_ar_valid,
   output logic        pAXI4_ar_ready,
   input  logic [31:0] pAXI4_ar_bits_addr,
   output logic        pAXI4_r_valid,
   input  logic        pAXI4_r_ready,
   output logic [31:0] pAXI4_r_bits_data,
   output logic [1:0]  pAXI4_r_bits_resp,
   input  logic        pAXI4_aw_valid,
   output logic        pAXI4_aw_ready,
   input  logic [31:0] pAXI4_aw_bits_addr,
   input  logic        pAXI4_w_valid,
   output logic        pAXI4_w_ready,
   input  logic [31:0] pAXI4_w_bits_data,
   input  logic [3:0]  pAXI4_w_bits_strb,
   output logic        pAXI4_b_valid,
   input  logic        pAXI4_b_ready,
   output logic [1:0]  pAXI4_b_bits_resp
);

   localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [33:0] LIMIT       = {2'b00, BASE_ADDR} + 34'(DEPTH_WORDS) * 34'd4;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   localparam logic [1:0] RD_IDLE = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] RD_RESP = 2'd2;

   localparam logic [1:0] WR_IDLE = 2'd0;
   localparam logic [1:0] WR_WAIT = 2'd1;
   localparam logic [1:0] WR_RESP = 2'd2;

   // Handshake rule on every channel: a beat transfers on the rising edge where
   // valid and ready are both high; a raised valid and its payload stay put until then.

   function automatic logic in_range(input logic [31:0] a);
      return ({2'b00, a} >= {2'b00, BASE_ADDR}) && ({2'b00, a} < LIMIT);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   logic [31:0] mem_q [DEPTH_WORDS];

   // ---------------------------------------------------------------- read side
   logic [1:0]       rd_state_q, rd_state_d;
   logic [3:0]       rd_cnt_q,   rd_cnt_d;
   logic [IDX_W-1:0] rd_idx_q,   rd_idx_d;
   logic             rd_ok_q,    rd_ok_d;
   logic [31:0]      r_data_q,   r_data_d;
   logic [1:0]       r_resp_q,   r_resp_d;
   logic             ar_ready_q, ar_ready_d;
   logic             rd_load;

   always_comb begin
      rd_state_d = rd_state_q;
      rd_cnt_d   = rd_cnt_q;
      rd_idx_d   = rd_idx_q;
      rd_ok_d    = rd_ok_q;
      r_data_d   = r_data_q;
      r_resp_d   = r_resp_q;
      rd_load    = 1'b0;
      case (rd_state_q)
         RD_IDLE: begin
            if (pAXI4_ar_valid && ar_ready_q) begin
               rd_idx_d = word_idx(pAXI4_ar_bits_addr);
               rd_ok_d  = in_range(pAXI4_ar_bits_addr);
               if (RD_LAT == 0) begin
                  rd_state_d = RD_RESP;
                  rd_load    = 1'b1;
               end else begin
                  rd_state_d = RD_WAIT;
                  rd_cnt_d   = 4'(RD_LAT - 1);
               end
            end
         end
         RD_WAIT: begin
            if (rd_cnt_q == 4'd0) begin
               rd_state_d = RD_RESP;
               rd_load    = 1'b1;
            end else begin
               rd_cnt_d = rd_cnt_q - 4'd1;
            end
         end
         RD_RESP: begin
            if (pAXI4_r_ready) rd_state_d = RD_IDLE;
         end
         default: rd_state_d = RD_IDLE;
      endcase
      // Data is sampled on the edge that enters RD_RESP, so a same-edge write is not seen.
      if (rd_load) begin
         r_data_d = rd_ok_d ? mem_q[rd_idx_d] : 32'h0;
         r_resp_d = rd_ok_d ? RESP_OKAY : RESP_SLVERR;
      end
      ar_ready_d = (rd_state_d == RD_IDLE);
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         rd_state_q <= RD_IDLE;
         rd_cnt_q   <= 4'd0;
         rd_idx_q   <= '0;
         rd_ok_q    <= 1'b0;
         r_data_q   <= 32'h0;
         r_resp_q   <= 2'b00;
         ar_ready_q <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_idx_q   <= rd_idx_d;
         rd_ok_q    <= rd_ok_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
         ar_ready_q <= ar_ready_d;
      end
   end

   assign pAXI4_ar_ready    = ar_ready_q;
   assign pAXI4_r_valid     = (rd_state_q == RD_RESP);
   assign pAXI4_r_bits_data = r_data_q;
   assign pAXI4_r_bits_resp = r_resp_q;

   // --------------------------------------------------------------- write side
   logic [1:0]       wr_state_q, wr_state_d;
   logic [3:0]       wr_cnt_q,   wr_cnt_d;
   logic             aw_held_q,  aw_held_d;
   logic             w_held_q,   w_held_d;
   logic [IDX_W-1:0] wr_idx_q,   wr_idx_d;
   logic             wr_ok_q,    wr_ok_d;
   logic [31:0]      w_data_q,   w_data_d;
   logic [3:0]       w_strb_q,   w_strb_d;
   logic [1:0]       b_resp_q,   b_resp_d;
   logic             aw_ready_q, aw_ready_d;
   logic             w_ready_q,  w_ready_d;
   logic             wr_commit;

   always_comb begin
      wr_state_d = wr_state_q;
      wr_cnt_d   = wr_cnt_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      wr_idx_d   = wr_idx_q;
      wr_ok_d    = wr_ok_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      b_resp_d   = b_resp_q;
      wr_commit  = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (pAXI4_aw_valid && aw_ready_q) begin
               aw_held_d = 1'b1;
               wr_idx_d  = word_idx(pAXI4_aw_bits_addr);
               wr_ok_d   = in_range(pAXI4_aw_bits_addr);
            end
            if (pAXI4_w_valid && w_ready_q) begin
               w_held_d = 1'b1;
               w_data_d = pAXI4_w_bits_data;
               w_strb_d = pAXI4_w_bits_strb;
            end
            // Departure waits for a cycle in which both halves are already held.
            if (aw_held_q && w_held_q) begin
               if (WR_LAT == 0) begin
                  wr_state_d = WR_RESP;
                  wr_commit  = 1'b1;
               end else begin
                  wr_state_d = WR_WAIT;
                  wr_cnt_d   = 4'(WR_LAT - 1);
               end
            end
         end
         WR_WAIT: begin
            if (wr_cnt_q == 4'd0) begin
               wr_state_d = WR_RESP;
               wr_commit  = 1'b1;
            end else begin
               wr_cnt_d = wr_cnt_q - 4'd1;
            end
         end
         WR_RESP: begin
            if (pAXI4_b_ready) begin
               wr_state_d = WR_IDLE;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
      if (wr_commit) b_resp_d = wr_ok_q ? RESP_OKAY : RESP_SLVERR;
      aw_ready_d = (wr_state_d == WR_IDLE) && !aw_held_d;
      w_ready_d  = (wr_state_d == WR_IDLE) && !w_held_d;
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         wr_state_q <= WR_IDLE;
         wr_cnt_q   <= 4'd0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         wr_idx_q   <= '0;
         wr_ok_q    <= 1'b0;
         w_data_q   <= 32'h0;
         w_strb_q   <= 4'h0;
         b_resp_q   <= 2'b00;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         wr_cnt_q   <= wr_cnt_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         wr_idx_q   <= wr_idx_d;
         wr_ok_q    <= wr_ok_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         b_resp_q   <= b_resp_d;
         aw_ready_q <= aw_ready_d;
         w_ready_q  <= w_ready_d;
      end
   end

   // Storage has no reset; a commit coinciding with reset is dropped with its transaction.
   always_ff @(posedge iClock) begin
      if (!iReset && wr_commit && wr_ok_q) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) mem_q[wr_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
         end
      end
   end

   assign pAXI4_aw_ready    = aw_ready_q;
   assign pAXI4_w_ready     = w_ready_q;
   assign pAXI4_b_valid     = (wr_state_q == WR_RESP);
   assign pAXI4_b_bits_resp = b_resp_q;

endmodule
